// File: rtl/scan_sel_gen_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scan_sel_gen_if : control/status bundle between a sweep controller and scan_sel_gen
// Revision 1.0
// ---------------------------------------------------------------------------
interface scan_sel_gen_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               dir;
  logic               one_shot;
  logic [DWELL_W-1:0] dwell;
  logic [7:0]         mask;
  logic [2:0]         sel;
  logic               en;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, dir, one_shot, dwell, mask,
    input  sel, en, busy, done
  );

  modport slave (
    input  start, stop, dir, one_shot, dwell, mask,
    output sel, en, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/scan_sel_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scan_sel_gen : masked, directional 3-to-8 decoder select sequencer with dwell
// Revision 1.0
// ---------------------------------------------------------------------------
module scan_sel_gen #(
  parameter int DWELL_W = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  scan_sel_gen_if.slave  bus_io
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             state_q;
  logic               dir_q;
  logic               one_shot_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [7:0]         mask_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [2:0]         sel_q;
  logic               en_q;
  logic               busy_q;
  logic               done_q;

  logic [2:0]         w_run_idx;
  logic               w_run_wrap;
  logic [2:0]         w_first_idx;

  // Nearest set bit strictly after cur (offset 1..8) in direction d; offset 8 is cur itself.
  function automatic logic [2:0] scan_next(input logic [7:0] m, input logic [2:0] cur,
                                           input logic d);
    logic [2:0] idx;
    logic [2:0] cand;
    idx = cur;
    for (int k = 8; k >= 1; k--) begin
      cand = d ? (cur - 3'(k)) : (cur + 3'(k));
      if (m[cand]) idx = cand;
    end
    return idx;
  endfunction

  always_comb begin
    w_run_idx   = scan_next(mask_q, sel_q, dir_q);
    w_run_wrap  = dir_q ? (w_run_idx >= sel_q) : (w_run_idx <= sel_q);
    // Searching from just past the opposite end yields the lowest/highest set bit.
    w_first_idx = scan_next(bus_io.mask, bus_io.dir ? 3'd0 : 3'd7, bus_io.dir);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dir_q      <= 1'b0;
      one_shot_q <= 1'b0;
      dwell_q    <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
      sel_q      <= 3'd0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus_io.start && !bus_io.stop && (bus_io.mask != 8'd0)) begin
            dir_q      <= bus_io.dir;
            one_shot_q <= bus_io.one_shot;
            dwell_q    <= bus_io.dwell;
            mask_q     <= bus_io.mask;
            cnt_q      <= '0;
            sel_q      <= w_first_idx;
            en_q       <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus_io.stop) begin
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q == dwell_q) begin
            cnt_q <= '0;
            if (w_run_wrap && one_shot_q) begin
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              sel_q <= w_run_idx;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_io.sel  = sel_q;
  assign bus_io.en   = en_q;
  assign bus_io.busy = busy_q;
  assign bus_io.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_sel_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_scan_sel_gen : directed self-checking bench for scan_sel_gen
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_scan_sel_gen;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  scan_sel_gen_if #(.DWELL_W(8)) bus ();

  scan_sel_gen #(.DWELL_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg(input logic d, input logic os, input logic [7:0] dw, input logic [7:0] m);
    bus.dir      = d;
    bus.one_shot = os;
    bus.dwell    = dw;
    bus.mask     = m;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    cfg(1'b0, 1'b0, 8'd0, 8'd0);

    // Reset state
    @(negedge clk);
    check("rst_sel",  32'(bus.sel),  32'd0);
    check("rst_en",   32'(bus.en),   32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    tick();

    // Continuous ascending sweep, full mask, dwell=2, past one wrap
    cfg(1'b0, 1'b0, 8'd2, 8'hFF);
    pulse_start();
    cfg(1'b1, 1'b1, 8'd0, 8'h01);  // changes while busy must not matter
    for (int i = 0; i < 27; i++) begin
      check("cont_sel",  32'(bus.sel),  32'((i / 3) % 8));
      check("cont_en",   32'(bus.en),   32'd1);
      check("cont_done", 32'(bus.done), 32'd0);
      tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("cont_stop_busy", 32'(bus.busy), 32'd0);

    // One-shot descending, mask 1010_0100, dwell=0
    cfg(1'b1, 1'b1, 8'd0, 8'hA4);
    pulse_start();
    check("os_sel0", 32'(bus.sel), 32'd7);
    check("os_en0",  32'(bus.en),  32'd1);
    tick();
    check("os_sel1", 32'(bus.sel), 32'd5);
    tick();
    check("os_sel2", 32'(bus.sel), 32'd2);
    check("os_en2",  32'(bus.en),  32'd1);
    tick();
    check("os_fin_en",   32'(bus.en),   32'd0);
    check("os_fin_done", 32'(bus.done), 32'd1);
    check("os_fin_busy", 32'(bus.busy), 32'd0);
    check("os_fin_sel",  32'(bus.sel),  32'd2);
    tick();
    check("os_idle_done", 32'(bus.done), 32'd0);
    check("os_idle_sel",  32'(bus.sel),  32'd2);

    // Single-line one-shot, dwell=3
    cfg(1'b0, 1'b1, 8'd3, 8'h08);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check("single_sel",  32'(bus.sel),  32'd3);
      check("single_en",   32'(bus.en),   32'd1);
      check("single_done", 32'(bus.done), 32'd0);
      tick();
    end
    check("single_fin_done", 32'(bus.done), 32'd1);
    check("single_fin_en",   32'(bus.en),   32'd0);
    tick();
    check("single_idle_done", 32'(bus.done), 32'd0);
    check("single_idle_busy", 32'(bus.busy), 32'd0);

    // Continuous dwell=1, start ignored in RUN, stop at sel=4
    cfg(1'b0, 1'b0, 8'd1, 8'hFF);
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      check("stop_seq_sel", 32'(bus.sel), 32'(i / 2));
      bus.start = (i == 3);
      tick();
    end
    bus.start = 1'b0;
    check("stop_pre_sel", 32'(bus.sel), 32'd4);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop_en",   32'(bus.en),   32'd0);
    check("stop_busy", 32'(bus.busy), 32'd0);
    check("stop_done", 32'(bus.done), 32'd0);
    tick();
    check("stop_done_later", 32'(bus.done), 32'd0);
    cfg(1'b0, 1'b0, 8'd0, 8'h60);
    pulse_start();
    check("restart_sel", 32'(bus.sel), 32'd5);
    check("restart_en",  32'(bus.en),  32'd1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("restart_stop_busy", 32'(bus.busy), 32'd0);

    // Ignored starts in IDLE
    cfg(1'b0, 1'b0, 8'd0, 8'h00);
    pulse_start();
    check("zmask_busy", 32'(bus.busy), 32'd0);
    check("zmask_en",   32'(bus.en),   32'd0);
    cfg(1'b0, 1'b0, 8'd0, 8'hFF);
    bus.stop = 1'b1;
    pulse_start();
    bus.stop = 1'b0;
    check("startstop_busy", 32'(bus.busy), 32'd0);
    check("startstop_en",   32'(bus.en),   32'd0);

    // Asynchronous reset mid-sweep at sel=6
    cfg(1'b0, 1'b0, 8'd0, 8'hFF);
    pulse_start();
    for (int i = 0; i < 6; i++) tick();
    check("arst_pre_sel", 32'(bus.sel), 32'd6);
    #2 rst = 1'b1;
    #1;
    check("arst_sel",  32'(bus.sel),  32'd0);
    check("arst_en",   32'(bus.en),   32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("arst_done", 32'(bus.done), 32'd0);
    tick();
    cfg(1'b1, 1'b1, 8'd0, 8'h81);
    pulse_start();
    check("post_sel0", 32'(bus.sel), 32'd7);
    check("post_en0",  32'(bus.en),  32'd1);
    tick();
    check("post_sel1", 32'(bus.sel), 32'd0);
    tick();
    check("post_done", 32'(bus.done), 32'd1);
    check("post_en",   32'(bus.en),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
